// File: rtl/ex1_ex2_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex1_ex2_pipe : dual-lane EX1->EX2 pipeline register with bubble insertion,
// backpressure hold and late-result fill. Optional macro: EX1_EX2_PERF_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ex1_ex2_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex1_valid,
  output logic              ex1_ready,
  input  logic              forward_stall,
  input  logic [DATA_W-1:0] ex1_pc,
  input  logic [REG_W-1:0]  ex1_rd0,
  input  logic [REG_W-1:0]  ex1_rd1,
  input  logic [DATA_W-1:0] ex1_data_0,
  input  logic [DATA_W-1:0] ex1_data_1,
  input  logic              ex1_data_0_valid,
  input  logic              ex1_data_1_valid,
  input  logic              ex2_ready,
  input  logic              ex2_late_valid_0,
  input  logic              ex2_late_valid_1,
  input  logic [DATA_W-1:0] ex2_late_data_0,
  input  logic [DATA_W-1:0] ex2_late_data_1,
  output logic              ex1_ex2_valid,
  output logic [DATA_W-1:0] ex1_ex2_pc,
  output logic [REG_W-1:0]  ex1_ex2_rd0,
  output logic [REG_W-1:0]  ex1_ex2_rd1,
  output logic [DATA_W-1:0] ex1_ex2_data_0,
  output logic [DATA_W-1:0] ex1_ex2_data_1,
  output logic              ex1_ex2_data_0_valid,
  output logic              ex1_ex2_data_1_valid
`ifdef EX1_EX2_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [REG_W-1:0]  rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              dv0_q, dv0_d, dv1_q, dv1_d;
  logic              accept;
  logic              rd0_zero, rd1_zero;

  assign ex1_ready = ~valid_q | ex2_ready;
  assign accept    = ex1_valid & ex1_ready & ~forward_stall & ~flush;
  assign rd0_zero  = (ex1_rd0 == '0);
  assign rd1_zero  = (ex1_rd1 == '0);

  // Defaults describe a bubble: forwarding matches rd without looking at valid,
  // so every non-valid state must carry rd0=rd1=0.
  always_comb begin
    valid_d = 1'b0;
    pc_d    = '0;
    rd0_d   = '0;
    rd1_d   = '0;
    data0_d = '0;
    data1_d = '0;
    dv0_d   = 1'b0;
    dv1_d   = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = ex1_pc;
      rd0_d   = ex1_rd0;
      rd1_d   = ex1_rd1;
      data0_d = rd0_zero ? '0 : ex1_data_0;
      data1_d = rd1_zero ? '0 : ex1_data_1;
      dv0_d   = rd0_zero | ex1_data_0_valid;
      dv1_d   = rd1_zero | ex1_data_1_valid;
    end else if (valid_q && !ex2_ready) begin
      valid_d = 1'b1;
      pc_d    = pc_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      data0_d = (!dv0_q && ex2_late_valid_0) ? ex2_late_data_0 : data0_q;
      data1_d = (!dv1_q && ex2_late_valid_1) ? ex2_late_data_1 : data1_q;
      dv0_d   = dv0_q | ex2_late_valid_0;
      dv1_d   = dv1_q | ex2_late_valid_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      dv0_q   <= dv0_d;
      dv1_q   <= dv1_d;
    end
  end

  assign ex1_ex2_valid        = valid_q;
  assign ex1_ex2_pc           = pc_q;
  assign ex1_ex2_rd0          = rd0_q;
  assign ex1_ex2_rd1          = rd1_q;
  assign ex1_ex2_data_0       = data0_q;
  assign ex1_ex2_data_1       = data1_q;
  assign ex1_ex2_data_0_valid = dv0_q;
  assign ex1_ex2_data_1_valid = dv1_q;

`ifdef EX1_EX2_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (ex1_valid && ex1_ready && forward_stall && !flush) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_bubble_cnt = perf_q;
`endif

endmodule
`default_nettype wire

// File: doc/ex1_ex2_pipe.md
Name: ex1_ex2_pipe

Overview:
- Dual-lane pipeline register between EX1 and EX2. Captures the two EX1 result lanes: destination register, result data, and a "result ready" flag.
- Presents those lanes to EX2 and, as the ex1_ex2_* bus, to the EX1 operand-forwarding logic.
- Inserts a bubble when forwarding requests a stall. Holds under EX2 backpressure.
- While held, fills late results that EX2 produces (load, multiply) into the register so that forwarding can use them.

Parameters:
- DATA_W, 32, width of result data and PC
- REG_W, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill the held entry and any incoming entry (branch mispredict or exception)
- ex1_valid  in  1  EX1 holds a valid instruction pair
- ex1_ready  out  1  the stage can accept EX1 contents this cycle
- forward_stall  in  1  EX1 operands not yet available; do not accept
- ex1_pc  in  DATA_W  PC of the pair
- ex1_rd0, ex1_rd1  in  REG_W  destination register of each lane (0 = no write)
- ex1_data_0, ex1_data_1  in  DATA_W  EX1 result of each lane
- ex1_data_0_valid, ex1_data_1_valid  in  1  the lane's result is final in EX1
- ex2_ready  in  1  EX2 consumes the held entry this cycle
- ex2_late_valid_0, ex2_late_valid_1  in  1  EX2 has finished the held lane's late result
- ex2_late_data_0, ex2_late_data_1  in  DATA_W  late result data
- ex1_ex2_valid  out  1  the held entry is valid
- ex1_ex2_pc  out  DATA_W  PC of the held entry
- ex1_ex2_rd0, ex1_ex2_rd1  out  REG_W  destination register of each held lane
- ex1_ex2_data_0, ex1_ex2_data_1  out  DATA_W  result data of each held lane
- ex1_ex2_data_0_valid, ex1_ex2_data_1_valid  out  1  the held lane's data may be forwarded

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0 except ex1_ready. ex1_ready is combinational and equals 1 after reset.
- ex1_ready = ~ex1_ex2_valid | ex2_ready. It is purely combinational and does not depend on forward_stall.
- accept = ex1_valid & ex1_ready & ~forward_stall & ~flush.
- Per-cycle priority, evaluated at the clock edge:
  1. flush: valid, rd0, rd1, data, data_valid and pc all go to 0.
  2. accept: load every field from the ex1_* inputs and set valid=1. Latency is one cycle.
  3. Held entry leaves (ex1_ex2_valid & ex2_ready) with no accept: the register becomes a bubble. valid=0, rd0=rd1=0, data=0, data_valid=0.
  4. Hold (ex1_ex2_valid & ~ex2_ready): keep all fields. Late fill applies per lane: if data_n_valid=0 and ex2_late_valid_n=1, load data_n from ex2_late_data_n and set data_n_valid=1.
  5. Idle (no valid entry, no accept): remain a bubble with all fields zeroed.
- Forwarding compares rd fields without checking valid. Every non-valid state must therefore present rd0=rd1=0.
- Lane with ex1_rdN=0 on accept: store rdN=0, data_N=0, data_N_valid=1, regardless of the inputs.
- forward_stall with ex2_ready=1 and a valid held entry: the entry leaves and a bubble is inserted, per rule 3.
- Late valid on a lane that is already valid is ignored. Late valid while the register holds no valid entry is ignored.
- Late fill and exit in the same cycle: the exit wins and the fill data is discarded.
- Both lanes are independent for late fill. Both lanes may fill in the same cycle.
- flush at the same time as an accept, exit or late fill: flush wins.

Optional Feature:
- Macro: EX1_EX2_PERF_EN.
- When defined: adds output perf_bubble_cnt (32 bits, reset 0). It increments by 1 on every clock edge where ex1_valid & ex1_ready & forward_stall & ~flush. It wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then accept: ex1_valid=1, rd0=3, rd1=7, data 0x11/0x22, both valids 1, ex2_ready=1. Next cycle: ex1_ex2_valid=1, rd0=3, rd1=7, data 0x11/0x22, both data_valid=1.
- Bubble: held entry present, ex2_ready=1, forward_stall=1, ex1_valid=1. Next cycle: ex1_ex2_valid=0, rd0=rd1=0, data_valid=0/0, ex1_ready=1. With the macro defined, perf_bubble_cnt=1.
- Late fill: accept rd0=5 with data_0_valid=0. Hold ex2_ready=0 for 2 cycles. Pulse ex2_late_valid_0 with 0xDEAD in the 2nd cycle. One cycle later: data_0=0xDEAD, data_0_valid=1, entry still held. Raise ex2_ready: the entry leaves.
- rd=0 lane: accept rd1=0 with data_1=0x55 and data_1_valid=0. Result: ex1_ex2_rd1=0, data_1=0, data_1_valid=1.
- Flush priority: flush=1 together with ex1_valid=1, forward_stall=0, and a held entry with ex2_ready=0. Next cycle: all fields 0, valid=0.
- Async reset mid-hold: assert rst between clock edges while an entry is held. Outputs go to 0 immediately without waiting for a clock edge. Deassert rst: the next accept loads normally.
